// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the 64x32 instruction memory: packs big-endian bytes into
// words, writes them from address 0 upward and stalls the CPU until the image is in.
module inst_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready
    // are both 1; byte_ready depends only on state, never on the byte inputs.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [1:0]        byte_idx, byte_idx_nx;
    logic [31:0]       asm_word, asm_word_nx;
    logic              last_seen, last_seen_nx;
    logic              mem_we_nx;
    logic [ADDR_W-1:0] mem_wa_nx;
    logic [31:0]       mem_wd_nx;
    logic              cpu_hold_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              error_nx;
    logic [ADDR_W:0]   word_count_nx;
    logic [31:0]       placed;
    logic              accept;

    assign byte_ready = (state == LOAD);
    assign accept     = byte_valid && byte_ready;

    // Lower bytes of asm_word are already zero, which gives the zero fill on a short tail.
    always_comb begin
        placed = asm_word;
        case (byte_idx)
            2'd0:    placed = {byte_in, 24'h000000};
            2'd1:    placed = {asm_word[31:24], byte_in, 16'h0000};
            2'd2:    placed = {asm_word[31:16], byte_in, 8'h00};
            default: placed = {asm_word[31:8], byte_in};
        endcase
    end

    always_comb begin
        state_nx      = state;
        byte_idx_nx   = byte_idx;
        asm_word_nx   = asm_word;
        last_seen_nx  = last_seen;
        mem_we_nx     = 1'b0;
        mem_wa_nx     = mem_wa;
        mem_wd_nx     = mem_wd;
        cpu_hold_nx   = cpu_hold;
        busy_nx       = busy;
        done_nx       = done;
        error_nx      = error;
        word_count_nx = word_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx      = LOAD;
                    byte_idx_nx   = 2'd0;
                    asm_word_nx   = 32'h0;
                    last_seen_nx  = 1'b0;
                    word_count_nx = '0;
                    error_nx      = 1'b0;
                    done_nx       = 1'b0;
                    cpu_hold_nx   = 1'b1;
                    busy_nx       = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    asm_word_nx = placed;
                    if (byte_idx == 2'd3 || byte_last) begin
                        state_nx     = WRITE;
                        last_seen_nx = byte_last;
                        mem_we_nx    = 1'b1;
                        mem_wa_nx    = word_count[ADDR_W-1:0];
                        mem_wd_nx    = placed;
                        if (byte_last && byte_idx != 2'd3) begin
                            error_nx = 1'b1;
                        end
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                    end
                end
            end
            WRITE: begin
                word_count_nx = word_count + ONE_COUNT;
                byte_idx_nx   = 2'd0;
                asm_word_nx   = 32'h0;
                // A full memory ends the load just like an explicit last byte.
                if (last_seen || word_count_nx == FULL_COUNT) begin
                    state_nx    = DONE;
                    done_nx     = 1'b1;
                    cpu_hold_nx = 1'b0;
                    busy_nx     = 1'b0;
                end else begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            asm_word   <= 32'h0;
            last_seen  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wa     <= '0;
            mem_wd     <= 32'h0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            byte_idx   <= byte_idx_nx;
            asm_word   <= asm_word_nx;
            last_seen  <= last_seen_nx;
            mem_we     <= mem_we_nx;
            mem_wa     <= mem_wa_nx;
            mem_wd     <= mem_wd_nx;
            cpu_hold   <= cpu_hold_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            error      <= error_nx;
            word_count <= word_count_nx;
        end
    end

endmodule
